matrix_framebuffer: RTL and testbench
=====================================

// Module: matrix_framebuffer
// PURPOSE
//  Double-buffered pixel store for the dual 8x8 LED matrix scanner. It answers the
//  scanner's row index with that row's left/right pixel bytes from the front buffer.
//  Game logic writes the back buffer over a valid/ready port. A commit request swaps
//  the buffers only at a frame boundary, so a half-drawn frame is never displayed.
// PARAMETERS
//  ROWS   8  rows per panel; row index width is $clog2(ROWS)
//  COLS   8  columns per panel; wr_data width is 2*COLS
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        async reset, active low
//  scan_row       in   3        row currently driven by the scanner
//  pixels_left    out  COLS     front-buffer left panel row at scan_row
//  pixels_right   out  COLS     front-buffer right panel row at scan_row
//  wr_valid       in   1        write request to the back buffer
//  wr_ready       out  1        back buffer accepts writes
//  wr_row         in   3        target row
//  wr_data        in   2*COLS   [2*COLS-1:COLS] = left, [COLS-1:0] = right
//  commit         in   1        request a buffer swap (pulse or level; sampled when wr_ready=1)
//  swap_done      out  1        1-cycle pulse when the new front buffer becomes visible
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-low.
//  - Reset values:
//      - Both buffers all-zero; front_sel=0; state IDLE; prev_row=0.
//      - wr_ready=1 after reset release; swap_done=0; pixels_* = 0.
//  - Read path:
//      - pixels_left/right = front[scan_row], combinational, 0-cycle latency.
//      - A scan_row value >= ROWS reads 0.
//  - Write: the handshake is wr_valid && wr_ready at a posedge. back[wr_row] <= wr_data.
//  - Frame boundary:
//      - prev_row <= scan_row every cycle.
//      - boundary = (prev_row==ROWS-1) && (scan_row==0).
//  - FSM:
//      - IDLE: wr_ready=1. commit -> PENDING.
//        - A write and a commit in the same cycle: the write lands first and is included in the swap.
//      - PENDING: wr_ready=0. On boundary -> SWAP.
//        - Extra commits are ignored. There is no timeout; it waits for the scanner.
//      - SWAP: one cycle; wr_ready=0. front_sel toggles, swap_done=1 the same cycle.
//        - Exit is CLEAR or IDLE, depending on the optional feature.
//        - New pixel data is visible from the cycle after SWAP.
//  - After a swap, the new back buffer holds the previously displayed frame (no copy).
//  - Reset mid-PENDING or mid-CLEAR: the pending commit is dropped, buffers are zeroed, front_sel=0.
//  - wr_row >= ROWS: the handshake completes and the data is discarded.
// CONFIGURATION
//  MATRIX_FB_CLEAR_EN
//  - Defined:
//      - After SWAP the FSM enters CLEAR and zeroes one back row per cycle (rows 0..ROWS-1).
//      - CLEAR lasts ROWS cycles with wr_ready=0, then -> IDLE.
//      - Writes presented during CLEAR stall, they are not lost.
//  - Undefined: there is no CLEAR state; SWAP -> IDLE and the back buffer keeps stale content.
// TESTING
//  1. Reset, scan_row sweeps 0..7 -> pixels_left/right = 0x00 on every row; wr_ready=1.
//  2. Write row3 = 0xA55A, then commit with scan_row=5 ->
//     - wr_ready=0 until the 7->0 wrap, then swap_done pulses once.
//     - When scan_row=3 is next read: pixels_left=0xA5, pixels_right=0x5A.
//  3. Write and commit in the same cycle (row7 = 0xFF00) -> the swap includes row7:
//     left=0xFF, right=0x00.
//  4. Second commit while PENDING -> exactly one swap_done. wr_valid held through PENDING
//     is accepted the first cycle wr_ready returns to 1.
//  5. Assert rst_n low during PENDING -> swap_done never pulses; all pixels 0; wr_ready=1 after release.
//  6. MATRIX_FB_CLEAR_EN defined:
//     - After the swap, wr_ready=0 for exactly 8 cycles.
//     - A following commit with no writes shows all-zero rows.
//     Undefined: the same sequence redisplays the old frame.

Source files
------------

// File: rtl/matrix_framebuffer.sv
// Double-buffered pixel store for the dual 8x8 LED matrix scanner; swaps on a frame boundary.
// Optional build macro MATRIX_FB_CLEAR_EN: zero the new back buffer row-by-row after each swap.
module matrix_framebuffer #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [$clog2(ROWS)-1:0]   scan_row,
    output logic [COLS-1:0]           pixels_left,
    output logic [COLS-1:0]           pixels_right,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [2*COLS-1:0]         wr_data,
    input  logic                      commit,
    output logic                      swap_done
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = 2 * COLS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;
`ifdef MATRIX_FB_CLEAR_EN
    localparam logic [1:0] ST_CLEAR   = 2'd3;
`endif

    logic [DW-1:0] r_buf [2][ROWS];
    logic          r_front_sel;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [RW-1:0] r_prev_row;
    logic          r_wr_ready;
    logic          r_swap_done;
    logic          w_boundary;
    logic          w_wr_fire;
    logic          w_wr_in_range;
    logic          w_back_sel;
    logic [DW-1:0] w_front_row;
`ifdef MATRIX_FB_CLEAR_EN
    logic [RW-1:0] r_clr_row;
`endif

    assign w_boundary    = (r_prev_row == RW'(ROWS - 1)) && (scan_row == '0);
    assign w_wr_fire     = wr_valid && r_wr_ready;
    assign w_wr_in_range = (int'(wr_row) < ROWS);
    assign w_back_sel    = ~r_front_sel;

    assign wr_ready     = r_wr_ready;
    assign swap_done    = r_swap_done;
    assign pixels_left  = w_front_row[DW-1:COLS];
    assign pixels_right = w_front_row[COLS-1:0];

    // Front-buffer row lookup for the scanner; out-of-range rows read blank.
    always_comb begin
        w_front_row = '0;
        if (int'(scan_row) < ROWS) begin
            w_front_row = r_buf[r_front_sel][scan_row];
        end else begin
            w_front_row = '0;
        end
    end

    // Swap sequencing: a commit waits for the scanner's last-row-to-row-0 wrap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (commit) w_state_nxt = ST_PENDING;
                else        w_state_nxt = ST_IDLE;
            end
            ST_PENDING: begin
                if (w_boundary) w_state_nxt = ST_SWAP;
                else            w_state_nxt = ST_PENDING;
            end
`ifdef MATRIX_FB_CLEAR_EN
            ST_SWAP:  w_state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (r_clr_row == RW'(ROWS - 1)) w_state_nxt = ST_IDLE;
                else                            w_state_nxt = ST_CLEAR;
            end
`else
            ST_SWAP:  w_state_nxt = ST_IDLE;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Control registers; handshake outputs are registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prev_row  <= '0;
            r_front_sel <= 1'b0;
            r_wr_ready  <= 1'b1;
            r_swap_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_row  <= scan_row;
            r_front_sel <= (r_state == ST_SWAP) ? ~r_front_sel : r_front_sel;
            r_wr_ready  <= (w_state_nxt == ST_IDLE);
            r_swap_done <= (w_state_nxt == ST_SWAP);
        end
    end

`ifdef MATRIX_FB_CLEAR_EN
    // Clear-row walker, restarted at row 0 for every clear pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_row <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_row <= r_clr_row + RW'(1);
        end else begin
            r_clr_row <= '0;
        end
    end
`endif

    // Pixel storage: writes only ever touch the back buffer; out-of-range rows are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_buf[b][r] <= '0;
                end
            end
        end else begin
            if (w_wr_fire && w_wr_in_range) begin
                r_buf[w_back_sel][wr_row] <= wr_data;
            end
`ifdef MATRIX_FB_CLEAR_EN
            if (r_state == ST_CLEAR) begin
                r_buf[w_back_sel][r_clr_row] <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_matrix_framebuffer.sv
// Directed self-checking bench for matrix_framebuffer; honours MATRIX_FB_CLEAR_EN when defined.
module tb_matrix_framebuffer;

`ifdef MATRIX_FB_CLEAR_EN
    localparam int          CLR_CYC = 8;
    localparam logic [15:0] STALE3  = 16'h0000;
    localparam logic [15:0] STALE7  = 16'h0000;
`else
    localparam int          CLR_CYC = 0;
    localparam logic [15:0] STALE3  = 16'hA55A;
    localparam logic [15:0] STALE7  = 16'hFF00;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  scan_row;
    logic [7:0]  pixels_left;
    logic [7:0]  pixels_right;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [15:0] wr_data;
    logic        commit;
    logic        swap_done;

    int n_tests  = 0;
    int n_fail   = 0;
    int swap_cnt = 0;
    int base_cnt;
    int n_cyc;

    matrix_framebuffer #(.ROWS(8), .COLS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_row     (scan_row),
        .pixels_left  (pixels_left),
        .pixels_right (pixels_right),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .commit       (commit),
        .swap_done    (swap_done)
    );

    always #10 clk = ~clk;

    // Count every cycle in which the swap pulse is seen.
    always @(posedge clk) begin
        if (swap_done === 1'b1) swap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input logic [2:0] row, input logic [15:0] exp);
        scan_row = row;
        #1;
        check(tag, {16'h0, pixels_left, pixels_right}, {16'h0, exp});
    endtask

    // Advance the scanner one row per cycle until the swap pulse is visible (bounded).
    task automatic advance_until_swap(output int n);
        n = 0;
        while (swap_done !== 1'b1 && n < 40) begin
            scan_row = scan_row + 3'd1;
            step();
            n++;
            if (swap_done !== 1'b1) check("pend_ready_low", {31'h0, wr_ready}, 32'h0);
        end
        check("swap_seen", {31'h0, swap_done}, 32'h1);
        check("swap_ready_low", {31'h0, wr_ready}, 32'h0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("ready_back", {31'h0, wr_ready}, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; scan_row = 3'd0; wr_valid = 1'b0; wr_row = 3'd0;
        wr_data = 16'h0; commit = 1'b0;
        step(); step();
        check("rst_swap_done", {31'h0, swap_done}, 32'h0);
        check_row("rst_pix", 3'd0, 16'h0000);
        rst_n = 1'b1;
        step();

        // 1: blank display after reset
        check("t1_ready", {31'h0, wr_ready}, 32'h1);
        for (int r = 0; r < 8; r++) check_row("t1_blank", 3'(r), 16'h0000);

        // 2: write row 3, commit at scan row 5, swap on the 7->0 wrap
        scan_row = 3'd5;
        wr_valid = 1'b1; wr_row = 3'd3; wr_data = 16'hA55A;
        step();
        wr_valid = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        check("t2_pend_ready", {31'h0, wr_ready}, 32'h0);
        check_row("t2_not_yet", 3'd3, 16'h0000);
        scan_row = 3'd5;
        advance_until_swap(n_cyc);
        check("t2_wrap_cycles", n_cyc, 32'd3);
        step();
        check("t2_swap_once", swap_cnt, 32'd1);
        wait_ready(n_cyc);
        check("t2_clear_len", n_cyc, CLR_CYC);
        check_row("t2_row3", 3'd3, 16'hA55A);
        check_row("t2_row0", 3'd0, 16'h0000);

        // 3: write and commit in the same cycle
        scan_row = 3'd0;
        step();
        wr_valid = 1'b1; wr_row = 3'd7; wr_data = 16'hFF00; commit = 1'b1;
        step();
        wr_valid = 1'b0; commit = 1'b0;
        check("t3_pend_ready", {31'h0, wr_ready}, 32'h0);
        advance_until_swap(n_cyc);
        step();
        wait_ready(n_cyc);
        check("t3_swap_cnt", swap_cnt, 32'd2);
        check_row("t3_row7", 3'd7, 16'hFF00);
        check_row("t3_row3", 3'd3, 16'h0000);

        // 4: repeated commit while pending, write held across the stall
        scan_row = 3'd0;
        step();
        base_cnt = swap_cnt;
        commit = 1'b1;
        step();
        wr_valid = 1'b1; wr_row = 3'd2; wr_data = 16'h1234;
        advance_until_swap(n_cyc);
        commit = 1'b0;
        step();
        wait_ready(n_cyc);
        check("t4_single_swap", swap_cnt - base_cnt, 32'd1);
        step();
        wr_valid = 1'b0;
        check_row("t4_row3_old", 3'd3, STALE3);
        check_row("t4_row7", 3'd7, 16'h0000);
        check_row("t4_row2_hidden", 3'd2, 16'h0000);
        scan_row = 3'd0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        advance_until_swap(n_cyc);
        step();
        wait_ready(n_cyc);
        check("t4_clear_len", n_cyc, CLR_CYC);
        check_row("t4_row2", 3'd2, 16'h1234);
        check_row("t6_row7_stale", 3'd7, STALE7);
        check_row("t4_row3", 3'd3, 16'h0000);

        // 5: reset while a commit is pending
        scan_row = 3'd0;
        wr_valid = 1'b1; wr_row = 3'd1; wr_data = 16'hBEEF;
        step();
        wr_valid = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        check("t5_pend_ready", {31'h0, wr_ready}, 32'h0);
        base_cnt = swap_cnt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("t5_ready", {31'h0, wr_ready}, 32'h1);
        for (int r = 0; r < 8; r++) check_row("t5_blank", 3'(r), 16'h0000);
        scan_row = 3'd0;
        for (int i = 0; i < 10; i++) begin
            scan_row = scan_row + 3'd1;
            step();
        end
        check("t5_no_swap", swap_cnt - base_cnt, 32'd0);
        check("t5_ready_end", {31'h0, wr_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
